// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq
// Description : Bit-serial WIDTH-bit ALU sequencer feeding a 1-bit ALU slice.
//               Optional build macro ALU_SERIAL_SIGNED_SLT_EN selects signed slt.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic [2:0]       slice_ctrl
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_xor = 3'b011;
    localparam logic [2:0] c_op_slt = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_inv;
    logic             w_bx;
    logic             w_sum;
    logic             w_cout;
    logic             w_bit;
    logic             w_lt;
    logic [WIDTH-1:0] w_res_full;
    logic [WIDTH-1:0] w_final;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_ctrl = 3'b000;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                slice_a    = r_a[0];
                slice_b    = r_b[0];
                slice_ctrl = r_op;
                if (r_cnt == c_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_accept   = (r_state == S_IDLE) && in_valid;
        w_last     = (r_state == S_RUN) && (r_cnt == c_last);
        w_inv      = (r_op == c_op_sub) || (r_op == c_op_slt);
        w_bx       = r_b[0] ^ w_inv;
        w_sum      = r_a[0] ^ w_bx ^ r_carry;
        w_cout     = (r_a[0] & w_bx) | (r_carry & (r_a[0] ^ w_bx));
        case (r_op)
            c_op_add, c_op_sub, c_op_slt: w_bit = w_sum;
            c_op_and:                     w_bit = r_a[0] & r_b[0];
            c_op_xor:                     w_bit = r_a[0] ^ r_b[0];
            default:                      w_bit = 1'b0;
        endcase
        w_res_full = {w_bit, r_res};
`ifdef ALU_SERIAL_SIGNED_SLT_EN
        // On the last bit r_carry is the carry into the MSB, so V = cin ^ cout.
        w_lt = w_sum ^ (r_carry ^ w_cout);
`else
        w_lt = ~w_cout;
`endif
        case (r_op)
            c_op_add, c_op_sub, c_op_and, c_op_xor: w_final = w_res_full;
            c_op_slt: w_final = {{(WIDTH-1){1'b0}}, w_lt};
            default:  w_final = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 3'b000;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_res    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_op    <= in_op;
            r_cnt   <= '0;
            r_carry <= (in_op == c_op_sub) || (in_op == c_op_slt);
            r_res   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_cout;
            r_res   <= w_res_full[WIDTH-1:1];
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_final;
                r_zero   <= (w_final == '0);
            end
        end
    end

    assign out_result = r_result;
    assign out_zero   = r_zero;

endmodule
`default_nettype wire
